// File: rtl/cla_pkg.sv
// Shared constants and helpers for the carry look-ahead adder.
// Group width, group propagate/generate function and a width legality check.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Group propagate/generate from per-bit p/g, flattened (no ripple).
  function automatic pg_t group_pg(input logic [GROUP_W-1:0] p, input logic [GROUP_W-1:0] g);
    pg_t r;
    r.p = &p;
    r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction

  function automatic bit width_ok(input int w);
    return (w > 0) && ((w % GROUP_W) == 0);
  endfunction

endpackage

// File: rtl/cla4_block.sv
// 4-bit lookahead group: flattened internal carries, sum bits and group P/G.
// Purely combinational; the group carry-in comes from the second-level unit.
module cla4_block
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               c_in,
  output logic [GROUP_W-1:0] s,
  output logic               P,
  output logic               G
);

  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] c;
  pg_t                pg;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);

  assign s  = p ^ c;
  assign pg = group_pg(p, g);
  assign P  = pg.p;
  assign G  = pg.g;

endmodule

// File: rtl/cla_adder.sv
// Two-level carry look-ahead adder, a + b + cin, result registered: 1-cycle latency.
// No backpressure: accepts one operation per cycle; outputs hold when in_valid=0.
module cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             grp_p,
  output logic             grp_g
);

  localparam int NG = WIDTH / GROUP_W;

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("cla_adder: WIDTH=%0d is not a positive multiple of %0d", WIDTH, GROUP_W);
  end

  logic [NG-1:0]    gp;
  logic [NG-1:0]    gg;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] s_comb;
  logic             all_g;

  // Carry into group k as a flat sum of products: each source (cin or G[j])
  // ANDed with the propagates of every group between it and k.
  function automatic logic la_carry(input logic [NG-1:0] pv, input logic [NG-1:0] gv,
                                    input logic c0, input int k);
    logic r;
    logic t;
    r = c0;
    for (int m = 0; m < NG; m++) begin
      if (m < k) r = r & pv[m];
    end
    for (int j = 0; j < NG; j++) begin
      t = 1'b0;
      if (j < k) begin
        t = gv[j];
        for (int m = 0; m < NG; m++) begin
          if ((m > j) && (m < k)) t = t & pv[m];
        end
      end
      r = r | t;
    end
    return r;
  endfunction

  for (genvar k = 0; k < NG; k++) begin : g_blk
    cla4_block u_blk (
      .a    (a[k*GROUP_W +: GROUP_W]),
      .b    (b[k*GROUP_W +: GROUP_W]),
      .c_in (gc[k]),
      .s    (s_comb[k*GROUP_W +: GROUP_W]),
      .P    (gp[k]),
      .G    (gg[k])
    );
  end

  for (genvar k = 0; k <= NG; k++) begin : g_carry
    assign gc[k] = la_carry(gp, gg, cin, k);
  end

  assign all_g = la_carry(gp, gg, 1'b0, NG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      grp_p     <= 1'b0;
      grp_g     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= s_comb;
        cout  <= gc[NG];
        grp_p <= &gp;
        grp_g <= all_g;
      end
    end
  end

endmodule

// File: tb/tb_cla_adder.sv
// Scoreboard bench for cla_adder at WIDTH=4 and WIDTH=16 with directed vectors.
module tb_cla_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        p;
    logic        g;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic        v4, c4;
  logic [3:0]  a4, b4;
  logic        o_v4, o_co4, o_p4, o_g4;
  logic [3:0]  o_s4;

  logic        v16, c16;
  logic [15:0] a16, b16;
  logic        o_v16, o_co16, o_p16, o_g16;
  logic [15:0] o_s16;

  exp_t q4[$];
  exp_t q16[$];
  exp_t e4, e16;
  logic [15:0] last4 = '0;
  logic [15:0] last16 = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cla_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
    .out_valid(o_v4), .sum(o_s4), .cout(o_co4), .grp_p(o_p4), .grp_g(o_g4)
  );

  cla_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .cin(c16),
    .out_valid(o_v16), .sum(o_s16), .cout(o_co16), .grp_p(o_p16), .grp_g(o_g16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic c,
                     input logic [3:0] s, input logic co, input logic p, input logic g);
    exp_t e;
    v4 = 1'b1; a4 = a; b4 = b; c4 = c;
    e.s = {12'h000, s}; e.co = co; e.p = p; e.g = g;
    q4.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [15:0] s, input logic co, input logic p, input logic g);
    exp_t e;
    v16 = 1'b1; a16 = a; b16 = b; c16 = c;
    e.s = s; e.co = co; e.p = p; e.g = g;
    q16.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: pops expectations on every valid output; checks hold otherwise.
  always @(negedge clk) begin
    if (rst) begin
      last4  = '0;
      last16 = '0;
    end else begin
      if (o_v4) begin
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL u4 unexpected out_valid: got 1 expected 0 (t=%0t)", $time);
        end else begin
          e4 = q4.pop_front();
          chk("u4 sum", 32'(o_s4), 32'(e4.s));
          chk("u4 cout", 32'(o_co4), 32'(e4.co));
          chk("u4 grp_p", 32'(o_p4), 32'(e4.p));
          chk("u4 grp_g", 32'(o_g4), 32'(e4.g));
        end
        last4 = {12'h000, o_s4};
      end else begin
        chk("u4 hold sum", 32'(o_s4), 32'(last4));
      end
      if (o_v16) begin
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL u16 unexpected out_valid: got 1 expected 0 (t=%0t)", $time);
        end else begin
          e16 = q16.pop_front();
          chk("u16 sum", 32'(o_s16), 32'(e16.s));
          chk("u16 cout", 32'(o_co16), 32'(e16.co));
          chk("u16 grp_p", 32'(o_p16), 32'(e16.p));
          chk("u16 grp_g", 32'(o_g16), 32'(e16.g));
        end
        last16 = o_s16;
      end else begin
        chk("u16 hold sum", 32'(o_s16), 32'(last16));
      end
    end
  end

  logic [1:0] sweep_sum [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

  initial begin
    logic [2:0]  t;
    logic [15:0] ra, rb;
    logic        rc, rv;
    logic [16:0] full, gen;
    exp_t        e;

    rst = 1'b1;
    v4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
    #1;
    chk("reset out_valid", 32'(o_v4), 32'(0));
    chk("reset sum", 32'(o_s4), 32'(0));
    chk("reset cout", 32'(o_co4), 32'(0));
    chk("reset grp_p", 32'(o_p4), 32'(0));
    chk("reset grp_g", 32'(o_g4), 32'(0));
    chk("reset out_valid16", 32'(o_v16), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-bit sweep, back-to-back
    for (int i = 0; i < 8; i++) begin
      t = 3'(i);
      go4({3'b000, t[2]}, {3'b000, t[1]}, t[0], {2'b00, sweep_sum[i]}, 1'b0, 1'b0, 1'b0);
    end

    // Full carry chain
    go4(4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
    go4(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    go4(4'hA, 4'h5, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);

    // Hold: invalid operands must not update the result
    go4(4'h7, 4'h8, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
    v4 = 1'b0; a4 = 4'h1; b4 = 4'h1; c4 = 1'b0;
    @(posedge clk); #1;
    chk("hold out_valid", 32'(o_v4), 32'(0));
    chk("hold sum", 32'(o_s4), 32'(15));

    go4(4'h9, 4'h9, 1'b0, 4'h2, 1'b1, 1'b0, 1'b1);
    v4 = 1'b0; a4 = 'x; b4 = 'x; c4 = 'x;
    @(posedge clk); #1;

    // Asynchronous reset mid-cycle with an operation pending
    v4 = 1'b1; a4 = 4'h5; b4 = 4'h3; c4 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(o_v4), 32'(0));
    chk("async rst sum", 32'(o_s4), 32'(0));
    chk("async rst cout", 32'(o_co4), 32'(0));
    @(posedge clk); #1;
    chk("rst held out_valid", 32'(o_v4), 32'(0));
    v4 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst no output", 32'(o_v4), 32'(0));
    chk("post-rst sum", 32'(o_s4), 32'(0));

    // WIDTH=16 cross-group carries
    go16(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    go16(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
    go16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    go16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);
    go16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    go16(16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    v16 = 1'b0;
    @(posedge clk); #1;

    // Random operands with random valid
    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rv = 1'($urandom);
      v16 = rv; a16 = ra; b16 = rb; c16 = rc;
      if (rv) begin
        full = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
        gen  = {1'b0, ra} + {1'b0, rb};
        e.s = full[15:0]; e.co = full[16]; e.p = &(ra ^ rb); e.g = gen[16];
        q16.push_back(e);
      end
      @(posedge clk); #1;
    end
    v16 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("q4 drained", 32'(q4.size()), 32'(0));
    chk("q16 drained", 32'(q16.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
